rv32_pipe_stage_buf: RTL and testbench
======================================

Name: rv32_pipe_stage_buf

Overview:
- Parametrised, handshaked successor to the fixed MEM/WB queue register; generic inter-stage register for the rv32 pipeline.
- Carries a generic payload plus instruction code, destination register, register-file control and halt fields.
- Adds valid/ready backpressure, an optional 2-entry skid buffer, synchronous flush with NOP-bubble injection, and a saturating stall counter.
- Instantiated between any two pipeline stages (IF/ID through MEM/WB).

Parameters:
- DATA_W, 128, generic payload width (e.g. alu_res/bshift/pc_ret/data_res concatenated).
- CTRL_W, 3, register-file control field width.
- RD_W, 5, destination register select width.
- NOP_CODE, 32'h00000013, instruction word presented for bubbles (addi x0,x0,0).
- HLT_RST, 1, reset value of hlt_out.
- SKID, 1, 1 = two-entry skid buffer; 0 = single register.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  upstream beat valid.
- ready_out  out  1  stage can accept a beat.
- data_in  in  DATA_W  payload.
- ctrl_in  in  CTRL_W  register-file control.
- rd_in  in  RD_W  destination register.
- hlt_in  in  1  halt flag.
- code_in  in  32  instruction word.
- valid_out  out  1  head entry valid.
- ready_in  in  1  downstream accepts head.
- data_out  out  DATA_W  head payload.
- ctrl_out  out  CTRL_W  head control.
- rd_out  out  RD_W  head destination register.
- hlt_out  out  1  head halt flag.
- code_out  out  32  head instruction.
- flush  in  1  synchronous flush (branch/trap redirect).
- stall_cnt  out  CNT_W  saturating count of cycles with valid_out=1 and ready_in=0.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous, active-low (rst_n), applied immediately and independent of clk.
- Reset values:
  - valid_out=0, data_out=0, ctrl_out=0, rd_out=0.
  - code_out=NOP_CODE, hlt_out=HLT_RST, stall_cnt=0.
  - SKID=1: ready_out=1 after reset.
  - Occupancy count=0.
- Handshake: beat accepted when valid_in && ready_out; beat retired when valid_out && ready_in; payload fields move as one beat.
- Bubble state: whenever valid_out=0, outputs are data_out=0, ctrl_out=0, rd_out=0, code_out=NOP_CODE.
  - hlt_out=0 in bubble, except the reset bubble, which holds HLT_RST until the first accepted beat.
- SKID=0 (single register):
  - ready_out = !valid_out || ready_in (combinational).
  - Latency 1 cycle.
  - Simultaneous retire and accept: the new beat is loaded.
- SKID=1 states (registered):
  - EMPTY (count 0): accept -> ONE.
  - ONE (count 1):
    - accept && !retire -> TWO (beat to skid slot).
    - retire && !accept -> EMPTY.
    - accept && retire -> ONE (new beat to head).
    - neither -> ONE.
  - TWO (count 2):
    - ready_out=0, no accept.
    - retire -> ONE; the skid entry moves to head on the same edge.
  - ready_out = (state != TWO), driven from a register, with no combinational path from ready_in.
  - Latency 1 cycle when not stalled; ordering strictly FIFO.
- Flush:
  - Next state EMPTY, all entries invalidated, outputs go to bubble values with hlt_out=0.
  - A beat offered in the flush cycle is dropped, even if valid_in && ready_out.
  - Flush overrides accept and retire. The retire handshake in the flush cycle is still counted by downstream; the flush affects the next-cycle state only.
- Stall counter:
  - Increments by 1 on each cycle with valid_out && !ready_in.
  - Saturates at all-ones; no wrap.
  - stall_clr sets it to 0 and takes priority over an increment in the same cycle.
  - flush does not clear it.
- Reset mid-operation: all entries lost immediately; no partial beat is retained.

Test Plan:
- Reset, then valid_in=1, data_in=128'h1, rd_in=5'd7, code_in=32'h00700093, ready_in=1 -> next cycle valid_out=1, rd_out=7, code_out=32'h00700093; before the accept, code_out=32'h00000013 and hlt_out=1.
- SKID=1, ready_in=0, three consecutive beats A, B, C offered -> A and B accepted, ready_out=0 from the cycle after B; C held upstream. Then ready_in=1 -> outputs A, B, C on consecutive cycles; stall_cnt equals the number of blocked cycles.
- SKID=1 in state TWO, assert flush with valid_in=1 -> next cycle valid_out=0, code_out=32'h00000013, rd_out=0, hlt_out=0, ready_out=1; the offered beat is never output.
- SKID=0, ready_in toggling 1,0,1,0 with a continuous stream -> no beat lost or duplicated; ready_out = !valid_out || ready_in every cycle.
- CNT_W=4, hold valid_out=1 and ready_in=0 for 20 cycles -> stall_cnt saturates at 15. Then stall_clr with ready_in=0 -> stall_cnt=0, resuming at 1 the following cycle.
- rst_n deasserted asynchronously mid-cycle while in state TWO -> outputs take reset values immediately without a clock edge; after release, the first beat passes with 1-cycle latency.

Source files
------------

// File: rtl/rv32_pipe_stage_buf.sv
// Generic handshaked rv32 inter-stage register: payload + code/rd/ctrl/halt,
// optional two-entry skid buffer, flush-to-bubble and a saturating stall counter.
module rv32_pipe_stage_buf #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned CTRL_W   = 3,
  parameter int unsigned RD_W     = 5,
  parameter logic [31:0] NOP_CODE = 32'h00000013,
  parameter logic        HLT_RST  = 1'b1,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              hlt_in,
  input  logic [31:0]       code_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              hlt_out,
  output logic [31:0]       code_out,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic              hlt;
    logic [31:0]       code;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  beat_t            head_q, head_d, skid_q, skid_d, beat_in;
  logic             rdy_q, rdy_d;
  logic             rst_bubble_q, rst_bubble_d;
  logic             accept, retire;
  logic [CNT_W-1:0] cnt_q;

  assign beat_in = '{data: data_in, ctrl: ctrl_in, rd: rd_in, hlt: hlt_in, code: code_in};

  assign valid_out = (state_q != EMPTY);
  // Skid mode breaks the ready_in -> ready_out path through a register.
  assign ready_out = (SKID != 0) ? rdy_q : (!valid_out || ready_in);

  assign accept = valid_in && ready_out;
  assign retire = valid_out && ready_in;

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    skid_d       = skid_q;
    rst_bubble_d = rst_bubble_q;
    if (flush) begin
      state_d      = EMPTY;
      rst_bubble_d = 1'b0;
    end else begin
      if (accept) rst_bubble_d = 1'b0;
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = beat_in;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            head_d = beat_in;
          end else if (accept) begin
            skid_d  = beat_in;
            state_d = TWO;
          end else if (retire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      skid_q       <= '0;
      rdy_q        <= 1'b1;
      rst_bubble_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      rdy_q        <= rdy_d;
      rst_bubble_q <= rst_bubble_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_clr) begin
      cnt_q <= '0;
    end else if (valid_out && !ready_in && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;

  // Bubbles present a NOP; halt shows HLT_RST only until the first real beat or flush.
  assign data_out = valid_out ? head_q.data : '0;
  assign ctrl_out = valid_out ? head_q.ctrl : '0;
  assign rd_out   = valid_out ? head_q.rd   : '0;
  assign code_out = valid_out ? head_q.code : NOP_CODE;
  assign hlt_out  = valid_out ? head_q.hlt  : (rst_bubble_q ? HLT_RST : 1'b0);

endmodule

// File: tb/tb_rv32_pipe_stage_buf.sv
// Scoreboard bench for rv32_pipe_stage_buf: three instances (skid, single register,
// skid with 4-bit stall counter) against a queue-based reference model.
module tb_rv32_pipe_stage_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [127:0] data;
    logic [2:0]   ctrl;
    logic [4:0]   rd;
    logic         hlt;
    logic [31:0]  code;
  } beat_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    beat_t       beat;
    logic [15:0] stall;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic  vin [3];
  beat_t bin [3];
  logic  rin [3];
  logic  fl  [3];
  logic  clr [3];

  logic vo0, ro0, ho0, vo1, ro1, ho1, vo2, ro2, ho2;
  logic [127:0] do0, do1, do2;
  logic [2:0] co0, co1, co2;
  logic [4:0] rdo0, rdo1, rdo2;
  logic [31:0] ic0, ic1, ic2;
  logic [15:0] sc0, sc1;
  logic [3:0] sc2;

  rv32_pipe_stage_buf u_skid (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[0]), .ready_out(ro0),
    .data_in(bin[0].data), .ctrl_in(bin[0].ctrl), .rd_in(bin[0].rd),
    .hlt_in(bin[0].hlt), .code_in(bin[0].code), .valid_out(vo0), .ready_in(rin[0]),
    .data_out(do0), .ctrl_out(co0), .rd_out(rdo0), .hlt_out(ho0), .code_out(ic0),
    .flush(fl[0]), .stall_cnt(sc0), .stall_clr(clr[0]));

  rv32_pipe_stage_buf #(.SKID(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[1]), .ready_out(ro1),
    .data_in(bin[1].data), .ctrl_in(bin[1].ctrl), .rd_in(bin[1].rd),
    .hlt_in(bin[1].hlt), .code_in(bin[1].code), .valid_out(vo1), .ready_in(rin[1]),
    .data_out(do1), .ctrl_out(co1), .rd_out(rdo1), .hlt_out(ho1), .code_out(ic1),
    .flush(fl[1]), .stall_cnt(sc1), .stall_clr(clr[1]));

  rv32_pipe_stage_buf #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_in(vin[2]), .ready_out(ro2),
    .data_in(bin[2].data), .ctrl_in(bin[2].ctrl), .rd_in(bin[2].rd),
    .hlt_in(bin[2].hlt), .code_in(bin[2].code), .valid_out(vo2), .ready_in(rin[2]),
    .data_out(do2), .ctrl_out(co2), .rd_out(rdo2), .hlt_out(ho2), .code_out(ic2),
    .flush(fl[2]), .stall_cnt(sc2), .stall_clr(clr[2]));

  obs_t obs [3];
  always_comb begin
    obs[0] = {vo0, ro0, do0, co0, rdo0, ho0, ic0, sc0};
    obs[1] = {vo1, ro1, do1, co1, rdo1, ho1, ic1, sc1};
    obs[2] = {vo2, ro2, do2, co2, rdo2, ho2, ic2, {12'd0, sc2}};
  end

  // Reference model: contents of each stage as a bounded FIFO of beats.
  beat_t       mq [3][$];
  logic        rbub [3];
  int unsigned mcnt [3];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic bit is_skid(int d);
    return d != 1;
  endfunction

  function automatic int unsigned cmax(int d);
    return (d == 2) ? 32'd15 : 32'd65535;
  endfunction

  function automatic bit model_ready(int d);
    if (is_skid(d)) return mq[d].size() < 2;
    return (mq[d].size() == 0) || rin[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      rbub[d] = 1'b1;
      mcnt[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      bit acc, ret, vld;
      vld = mq[d].size() > 0;
      acc = vin[d] && model_ready(d);
      ret = vld && rin[d];
      if (clr[d]) mcnt[d] = 0;
      else if (vld && !rin[d] && mcnt[d] < cmax(d)) mcnt[d] = mcnt[d] + 1;
      if (fl[d]) begin
        mq[d].delete();
        rbub[d] = 1'b0;
      end else begin
        if (ret) void'(mq[d].pop_front());
        if (acc) begin
          mq[d].push_back(bin[d]);
          rbub[d] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic cmp(int d, string nm, logic [175:0] act, logic [175:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL dut%0d %s at %0t: got %h expected %h", d, nm, $time, act, exp);
  endtask

  task automatic check(int d);
    beat_t exp;
    logic  ev, er;
    ev = mq[d].size() > 0;
    er = model_ready(d);
    if (ev) begin
      exp = mq[d][0];
    end else begin
      exp      = '0;
      exp.code = NOP;
      exp.hlt  = rbub[d];
    end
    cmp(d, "valid", 176'(obs[d].valid), 176'(ev));
    cmp(d, "ready", 176'(obs[d].ready), 176'(er));
    cmp(d, "beat",  176'(obs[d].beat),  176'(exp));
    cmp(d, "stall", 176'(obs[d].stall), 176'(mcnt[d]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check(d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(logic v, logic r, logic f, logic c);
    for (int d = 0; d < 3; d++) begin
      vin[d] = v;
      rin[d] = r;
      fl[d]  = f;
      clr[d] = c;
    end
  endtask

  function automatic beat_t rand_beat();
    return {$urandom, $urandom, $urandom, $urandom, 3'($urandom), 5'($urandom),
            1'($urandom), $urandom};
  endfunction

  task automatic offer_all(beat_t b);
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b1;
      bin[d] = b;
    end
  endtask

  initial begin
    beat_t b;
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) bin[d] = '0;
    #12 rst_n = 1'b1;
    tick();

    // First beat after reset: NOP/hlt bubble before, 1-cycle latency after.
    b = '0;
    b.data = 128'h1;
    b.rd   = 5'd7;
    b.code = 32'h00700093;
    offer_all(b);
    tick();
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();

    // Three beats against a blocked consumer, then drain.
    set_all(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) b = rand_beat();
      offer_all(b);
      tick();
    end
    for (int d = 0; d < 3; d++) rin[d] = 1'b1;
    tick();
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();

    // Fill, then flush with a beat offered in the flush cycle.
    set_all(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      offer_all(rand_beat());
      tick();
    end
    offer_all(rand_beat());
    for (int d = 0; d < 3; d++) fl[d] = 1'b1;
    tick();
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // Randomised traffic with occasional flush and counter clear.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        vin[d] = ($urandom % 4) != 0;
        bin[d] = rand_beat();
        rin[d] = (i % 50 < 25) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
        fl[d]  = ($urandom % 20) == 0;
        clr[d] = ($urandom % 16) == 0;
      end
      tick();
    end

    // Long stall to saturate the 4-bit counter, then clear while still stalled.
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    offer_all(rand_beat());
    tick();
    set_all(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    for (int d = 0; d < 3; d++) clr[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) clr[d] = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-cycle while full.
    for (int i = 0; i < 2; i++) begin
      offer_all(rand_beat());
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check(d);
    #2 rst_n = 1'b1;
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    offer_all(rand_beat());
    tick();
    set_all(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
